// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch timebase and BCD counter.
package stopwatch_pkg;

  localparam int unsigned DIGIT_WIDTH = 4;
  localparam int unsigned DIGIT_MAX   = 9;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned clog2(input longint unsigned value);
    longint unsigned v;
    int unsigned     bits;
    v    = (value > 64'd0) ? value - 64'd1 : 64'd0;
    bits = 0;
    while (v > 64'd0) begin
      v    = v >> 1;
      bits = bits + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Clock divider: one registered single-cycle tick every DIVIDE enabled cycles.
module stopwatch_tick_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ    = 100000000,
  parameter int unsigned OUTPUT_CLOCK_PERIOD_IN_SECONDS = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic clkOut
);

  localparam longint unsigned DIVIDE =
    64'(BOARD_CLOCK_FREQUENCY_IN_HZ) * 64'(OUTPUT_CLOCK_PERIOD_IN_SECONDS);
  localparam int unsigned CNT_W = (clog2(DIVIDE) < 1) ? 1 : clog2(DIVIDE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDE - 64'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Paused cycles hold the count so a resumed period is neither lost nor extended.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign clkOut = tick_q;

endmodule

// File: rtl/stopwatch_tick_counter.sv
// Stopwatch datapath: divider tick feeding a cascaded NUM_DIGITS-digit BCD counter.
module stopwatch_tick_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ    = 100000000,
  parameter int unsigned OUTPUT_CLOCK_PERIOD_IN_SECONDS = 1,
  parameter int unsigned NUM_DIGITS                     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  output logic                              clkOut,
  output logic [DIGIT_WIDTH*NUM_DIGITS-1:0] numberOut,
  output logic                              wrap
);

  localparam logic [DIGIT_WIDTH-1:0] NINE = DIGIT_WIDTH'(DIGIT_MAX);

  logic                                tick;
  logic [NUM_DIGITS:0]                 carry;
  logic [DIGIT_WIDTH*NUM_DIGITS-1:0]   digits;
  logic                                wrap_q, wrap_d;

  stopwatch_tick_gen #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ    (BOARD_CLOCK_FREQUENCY_IN_HZ),
    .OUTPUT_CLOCK_PERIOD_IN_SECONDS (OUTPUT_CLOCK_PERIOD_IN_SECONDS)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .clkOut (tick)
  );

  // carry[k] is set when the tick must reach digit k (all lower digits at 9).
  always_comb begin
    carry    = '0;
    carry[0] = tick;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      carry[k+1] = carry[k] && (digits[k*DIGIT_WIDTH +: DIGIT_WIDTH] == NINE);
    end
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [DIGIT_WIDTH-1:0] digit_q, digit_d;

    always_comb begin
      digit_d = digit_q;
      if (carry[k]) begin
        digit_d = (digit_q == NINE) ? '0 : digit_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) digit_q <= '0;
      else      digit_q <= digit_d;
    end

    assign digits[k*DIGIT_WIDTH +: DIGIT_WIDTH] = digit_q;
  end

  always_comb begin
    wrap_d = carry[NUM_DIGITS];
  end

  always_ff @(posedge clk) begin
    if (!rst) wrap_q <= 1'b0;
    else      wrap_q <= wrap_d;
  end

  assign clkOut    = tick;
  assign numberOut = digits;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_tick_counter.sv
// Self-checking bench for stopwatch_tick_counter (DIVIDE=10, two BCD digits).
module tb_stopwatch_tick_counter;

  localparam int DIV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       clk_out;
  logic [7:0] number_out;
  logic       wrap;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: counts of enabled cycles and ticks since reset.
  int m_en_cnt = 0;
  int m_ticks  = 0;
  bit m_clk    = 0;
  bit m_wrap   = 0;

  stopwatch_tick_counter #(
    .BOARD_CLOCK_FREQUENCY_IN_HZ    (10),
    .OUTPUT_CLOCK_PERIOD_IN_SECONDS (1),
    .NUM_DIGITS                     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clkOut    (clk_out),
    .numberOut (number_out),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int n);
    int v;
    v = n % 100;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] exp_num();
    return to_bcd(m_ticks);
  endfunction

  // A tick seen on clkOut is counted one edge later; the count is modulo 100.
  task automatic step(input logic en_i, input logic rst_i);
    enable = en_i;
    rst    = rst_i;
    @(posedge clk);
    if (!rst_i) begin
      m_en_cnt = 0; m_ticks = 0; m_clk = 0; m_wrap = 0;
    end else begin
      m_wrap  = m_clk && (m_ticks % 100 == 99);
      m_ticks = m_ticks + (m_clk ? 1 : 0);
      if (en_i) begin
        m_en_cnt = m_en_cnt + 1;
        m_clk    = (m_en_cnt % DIV == 0);
      end else begin
        m_clk = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if (clk_out !== 1'b0 || number_out !== 8'h00 || wrap !== 1'b0)
        $display("FAIL reset_hold: clkOut=%b numberOut=%h wrap=%b, expected 0/00/0", clk_out, number_out, wrap);
      else n_pass++;
    end
    step(1'b1, 1'b1);
    n_checks++;
    if (clk_out !== 1'b0 || number_out !== 8'h00 || wrap !== 1'b0)
      $display("FAIL reset_release: clkOut=%b numberOut=%h wrap=%b, expected 0/00/0", clk_out, number_out, wrap);
    else n_pass++;
  endtask

  task automatic test_cadence();
    do_reset();
    for (int c = 1; c <= 50; c++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if (clk_out !== ((c % DIV) == 0))
        $display("FAIL cadence_clkOut: cycle %0d got %b expected %b", c, clk_out, (c % DIV) == 0);
      else n_pass++;
      n_checks++;
      if (number_out !== exp_num())
        $display("FAIL cadence_number: cycle %0d got %h expected %h", c, number_out, exp_num());
      else n_pass++;
    end
    step(1'b1, 1'b1);
    n_checks++;
    if (number_out !== 8'h05)
      $display("FAIL cadence_final: got %h expected 05", number_out);
    else n_pass++;
  endtask

  task automatic test_carry();
    logic [7:0] prev;
    do_reset();
    prev = 8'h00;
    for (int c = 1; c <= 101; c++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if (number_out[3:0] > 4'd9 || number_out[7:4] > 4'd9 || number_out !== exp_num())
        $display("FAIL carry_number: cycle %0d got %h expected %h", c, number_out, exp_num());
      else n_pass++;
      if (c == 101) begin
        n_checks++;
        if (prev !== 8'h09 || number_out !== 8'h10)
          $display("FAIL carry_step: got %h -> %h expected 09 -> 10", prev, number_out);
        else n_pass++;
      end
      prev = number_out;
    end
  endtask

  task automatic test_pause();
    logic [7:0] held;
    do_reset();
    for (int c = 0; c < 4; c++) step(1'b1, 1'b1);
    held = number_out;
    for (int c = 0; c < 7; c++) begin
      step(1'b0, 1'b1);
      n_checks++;
      if (clk_out !== 1'b0 || number_out !== held)
        $display("FAIL pause_hold: clkOut=%b numberOut=%h expected 0/%h", clk_out, number_out, held);
      else n_pass++;
    end
    for (int c = 1; c <= 6; c++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if (clk_out !== (c == 6))
        $display("FAIL pause_resume: enabled cycle %0d clkOut=%b expected %b", c, clk_out, c == 6);
      else n_pass++;
    end
  endtask

  task automatic test_rollover();
    int wraps;
    do_reset();
    wraps = 0;
    for (int c = 1; c <= 1002; c++) begin
      step(1'b1, 1'b1);
      if (wrap === 1'b1) wraps++;
      n_checks++;
      if (number_out !== exp_num() || wrap !== m_wrap)
        $display("FAIL rollover_model: cycle %0d numberOut=%h wrap=%b expected %h/%b", c, number_out, wrap, exp_num(), m_wrap);
      else n_pass++;
      if (c == 1000 || c == 1001) begin
        n_checks++;
        if (number_out !== ((c == 1000) ? 8'h99 : 8'h00) || wrap !== (c == 1001))
          $display("FAIL rollover_edge: cycle %0d numberOut=%h wrap=%b", c, number_out, wrap);
        else n_pass++;
      end
    end
    n_checks++;
    if (wraps != 1) $display("FAIL rollover_wrap_count: got %0d expected 1", wraps);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 15; c++) step(1'b1, 1'b1);
    n_checks++;
    if (number_out !== 8'h01) $display("FAIL mid_precount: got %h expected 01", number_out);
    else n_pass++;
    step(1'b1, 1'b0);
    n_checks++;
    if (number_out !== 8'h00 || clk_out !== 1'b0)
      $display("FAIL mid_reset: numberOut=%h clkOut=%b expected 00/0", number_out, clk_out);
    else n_pass++;
    for (int c = 1; c <= 10; c++) begin
      step(1'b1, 1'b1);
      n_checks++;
      if (clk_out !== (c == 10))
        $display("FAIL mid_next_tick: cycle %0d clkOut=%b expected %b", c, clk_out, c == 10);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic en_r, rst_r;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      en_r  = ($urandom_range(0, 4) != 0);
      rst_r = ($urandom_range(0, 199) != 0);
      step(en_r, rst_r);
      n_checks++;
      if (clk_out !== m_clk || number_out !== exp_num() || wrap !== m_wrap)
        $display("FAIL random: cycle %0d got %b/%h/%b expected %b/%h/%b", c, clk_out, number_out, wrap, m_clk, exp_num(), m_wrap);
      else n_pass++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_cadence();
    test_carry();
    test_pause();
    test_rollover();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_tick_counter.md
Name: stopwatch_tick_counter

Overview:
Timebase plus decimal counter for the stopwatch datapath. A clock divider turns the board clock into a single-cycle tick every OUTPUT_CLOCK_PERIOD_IN_SECONDS. A cascaded BCD counter advances by one on each tick. The BCD digits feed the display logic downstream.

Parameters:
BOARD_CLOCK_FREQUENCY_IN_HZ, 100000000, board clock frequency in Hz
OUTPUT_CLOCK_PERIOD_IN_SECONDS, 1, tick period in seconds (integer, >=1)
NUM_DIGITS, 4, number of cascaded BCD digits (1..8)

Ports:
clk  in  1  board clock; all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
enable  in  1  1 = run; 0 = freeze divider and counter (pause)
clkOut  out  1  one-cycle tick pulse, registered
numberOut  out  4*NUM_DIGITS  BCD count, digit 0 in bits [3:0] (least significant)
wrap  out  1  one-cycle pulse when the count rolls over from all-9s to 0, registered

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst sampled 0 at a rising edge of clk clears all state; the clock is named clk and the reset rst.
- DIVIDE = BOARD_CLOCK_FREQUENCY_IN_HZ * OUTPUT_CLOCK_PERIOD_IN_SECONDS.
- Divider counter width is clog2(DIVIDE), minimum 1.
- Reset values: divider counter 0, clkOut 0, numberOut 0 (all digits), wrap 0.
- Divider:
  - When enable=1, the divider counter increments each cycle.
  - When the counter equals DIVIDE-1, it returns to 0 and clkOut=1 for exactly the next cycle; otherwise clkOut=0.
  - The first tick is visible DIVIDE cycles after the first enabled cycle following reset. Ticks repeat every DIVIDE enabled cycles.
- enable=0: divider counter holds its value and clkOut=0. Resuming continues from the held count, with no lost or extra partial period.
- DIVIDE=1: clkOut=1 on every enabled cycle.
- Counter:
  - Advances on cycles where clkOut=1. This is a registered tick, so numberOut updates one cycle after clkOut is high.
  - Digit k increments when the tick is present and digits 0..k-1 all equal 9.
  - A digit at 9 that increments goes to 0.
  - Digit values never leave 0..9.
- Rollover: when all digits are 9 and a tick arrives, all digits become 0 and wrap=1 for that one cycle.
- Reset mid-period: clears divider progress and count immediately; no tick is emitted in the reset cycle.
- Reset asserted together with a tick: reset wins.

Decomposition:
- Package stopwatch_pkg:
  - DIGIT_WIDTH = 4
  - DIGIT_MAX = 9
  - function clog2
- Sub-module stopwatch_tick_gen (the divider):
  - parameters BOARD_CLOCK_FREQUENCY_IN_HZ, OUTPUT_CLOCK_PERIOD_IN_SECONDS
  - ports clk, rst, enable, clkOut
- The BCD cascade is a generate loop in the top module.

Test Plan:
(All with BOARD_CLOCK_FREQUENCY_IN_HZ=10, OUTPUT_CLOCK_PERIOD_IN_SECONDS=1, NUM_DIGITS=2, so DIVIDE=10.)
- Reset: hold rst=0 for 2 cycles, enable=1 -> clkOut=0, numberOut=8'h00, wrap=0 during and on the first cycle after release.
- Tick cadence: enable=1 for 50 cycles after reset -> clkOut high exactly on cycles 10, 20, 30, 40, 50, each for one cycle; numberOut=8'h05 after the last update.
- Digit carry: run 100 cycles -> numberOut goes 8'h09 then 8'h10 on the 10th tick; neither nibble ever exceeds 9.
- Pause: enable=0 for 7 cycles after 4 enabled cycles, then enable=1 -> next tick arrives after 6 more enabled cycles; clkOut=0 and numberOut unchanged while paused.
- Rollover: run 1000 enabled cycles -> numberOut goes 8'h99 to 8'h00 on the 100th tick, with wrap=1 for one cycle.
- Reset mid-operation: assert rst=0 at cycle 15 (count 8'h01) -> numberOut=8'h00 next cycle; next tick occurs 10 enabled cycles after release.
